// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: FSM state encoding and the
// default widths of the configuration fields and event counters.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int LEN_W_DEF = 8;
  localparam int NUM_W_DEF = 4;
  localparam int EVT_W_DEF = 8;

endpackage

// File: rtl/sat_edge_counter.sv
// Rising-edge detector feeding a saturating event counter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   evt_in      level input whose rising edges are counted
//   en          edges are counted only while high
//   clr         synchronous clear, wins over a same-cycle edge
//   cnt         event count, holds at all-ones
module sat_edge_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         evt_in,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_ONE = 1;

  logic         evt_q, evt_d;
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    evt_d = evt_in;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && evt_in && !evt_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      evt_q <= evt_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Drives the detector input A with a train of num_pulses high/low pulses,
// flags completion with a one-cycle done, and counts K1/K2 rising edges
// seen while the train is running.
// Ports:
//   Clock, Reset          clock and asynchronous active-low reset
//   start                 run request, only looked at in IDLE
//   high_len, low_len     phase lengths in cycles (0 behaves as 1)
//   num_pulses            pulses per run (0 gives an empty run)
//   K1, K2                detector outputs
//   A, busy, done         registered sequencer outputs
//   k1_cnt, k2_cnt        saturating rising-edge counts for the current/last run
//
// state | meaning
// IDLE  | waiting for start
// HIGH  | A held high, phase counter running
// LOW   | A held low, phase counter running
// DONE  | one-cycle completion flag
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int NUM_W = NUM_W_DEF,
  parameter int EVT_W = EVT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             K1,
  input  logic             K2,
  output logic             A,
  output logic             busy,
  output logic             done,
  output logic [EVT_W-1:0] k1_cnt,
  output logic [EVT_W-1:0] k2_cnt
);

  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [NUM_W-1:0] NUM_ONE = 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  // Latched phase lengths are kept as (length-1) so they load the
  // down-counter directly; the 0->1 rule folds into the same subtraction.
  logic [LEN_W-1:0] hi_m1_q, hi_m1_d;
  logic [LEN_W-1:0] lo_m1_q, lo_m1_d;
  logic [NUM_W-1:0] pulse_q, pulse_d;
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_clr;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_m1_d = hi_m1_q;
    lo_m1_d = lo_m1_q;
    pulse_d = pulse_q;
    cnt_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          hi_m1_d = (high_len == '0) ? '0 : high_len - LEN_ONE;
          lo_m1_d = (low_len == '0) ? '0 : low_len - LEN_ONE;
          pulse_d = num_pulses;
          cnt_clr = 1'b1;
          if (num_pulses != '0) begin
            state_d = ST_HIGH;
            phase_d = (high_len == '0) ? '0 : high_len - LEN_ONE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (phase_q == '0) begin
          state_d = ST_LOW;
          phase_d = lo_m1_q;
          pulse_d = pulse_q - NUM_ONE;
        end else begin
          phase_d = phase_q - LEN_ONE;
        end
      end
      ST_LOW: begin
        if (phase_q == '0) begin
          if (pulse_q != '0) begin
            state_d = ST_HIGH;
            phase_d = hi_m1_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          phase_d = phase_q - LEN_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the
    // state register rather than lagging it by a cycle.
    a_d    = (state_d == ST_HIGH);
    busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      hi_m1_q <= '0;
      lo_m1_q <= '0;
      pulse_q <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_m1_q <= hi_m1_d;
      lo_m1_q <= lo_m1_d;
      pulse_q <= pulse_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sat_edge_counter #(.W(EVT_W)) u_k1_cnt (
    .clk    (Clock),
    .rst_n  (Reset),
    .evt_in (K1),
    .en     (busy_q),
    .clr    (cnt_clr),
    .cnt    (k1_cnt)
  );

  sat_edge_counter #(.W(EVT_W)) u_k2_cnt (
    .clk    (Clock),
    .rst_n  (Reset),
    .evt_in (K2),
    .en     (busy_q),
    .clr    (cnt_clr),
    .cnt    (k2_cnt)
  );

  assign A    = a_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: a default-width instance and an EVT_W=2 instance
// share all inputs and are compared each cycle against a queue-based model
// that expands each accepted run into its expected per-cycle outputs.
module tb_pulse_seq_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic [7:0] high_len, low_len;
  logic [3:0] num_pulses;
  logic       K1, K2;

  logic       A, busy, done;
  logic [7:0] k1_cnt, k2_cnt;
  logic       s_a, s_busy, s_done;
  logic [1:0] s_k1, s_k2;

  always #5 Clock = ~Clock;

  pulse_seq_ctrl dut (
    .Clock(Clock), .Reset(Reset), .start(start),
    .high_len(high_len), .low_len(low_len), .num_pulses(num_pulses),
    .K1(K1), .K2(K2),
    .A(A), .busy(busy), .done(done), .k1_cnt(k1_cnt), .k2_cnt(k2_cnt)
  );

  pulse_seq_ctrl #(.EVT_W(2)) dut_sat (
    .Clock(Clock), .Reset(Reset), .start(start),
    .high_len(high_len), .low_len(low_len), .num_pulses(num_pulses),
    .K1(K1), .K2(K2),
    .A(s_a), .busy(s_busy), .done(s_done), .k1_cnt(s_k1), .k2_cnt(s_k2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected outputs per cycle as a queue of {a,busy,done}.
  typedef struct packed { logic a; logic b; logic d; } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int   m_k1, m_k2, m_s1, m_s2;
  logic k1p, k2p;

  task automatic model_reset();
    exp_q.delete();
    cur  = '0;
    m_k1 = 0; m_k2 = 0; m_s1 = 0; m_s2 = 0;
    k1p  = 1'b0; k2p = 1'b0;
  endtask

  task automatic build_run(input int h_in, input int l_in, input int n);
    int h, l;
    h = (h_in == 0) ? 1 : h_in;
    l = (l_in == 0) ? 1 : l_in;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) exp_q.push_back('{a:1'b1, b:1'b1, d:1'b0});
      for (int i = 0; i < l; i++) exp_q.push_back('{a:1'b0, b:1'b1, d:1'b0});
    end
    exp_q.push_back('{a:1'b0, b:1'b0, d:1'b1});
  endtask

  task automatic check_outputs();
    chk("A",       A,      cur.a);
    chk("busy",    busy,   cur.b);
    chk("done",    done,   cur.d);
    chk("k1_cnt",  k1_cnt, m_k1);
    chk("k2_cnt",  k2_cnt, m_k2);
    chk("sat_A",   s_a,    cur.a);
    chk("sat_k1",  s_k1,   m_s1);
    chk("sat_k2",  s_k2,   m_s2);
  endtask

  // One clock: inputs are already applied; advance the model with the
  // values seen at the edge and compare just after it.
  task automatic step();
    logic r1, r2;
    @(posedge Clock);
    #1;
    r1 = K1 & ~k1p;
    r2 = K2 & ~k2p;
    if (cur.b) begin
      if (r1) begin
        m_k1 = (m_k1 < 255) ? m_k1 + 1 : 255;
        m_s1 = (m_s1 < 3) ? m_s1 + 1 : 3;
      end
      if (r2) begin
        m_k2 = (m_k2 < 255) ? m_k2 + 1 : 255;
        m_s2 = (m_s2 < 3) ? m_s2 + 1 : 3;
      end
    end
    k1p = K1;
    k2p = K2;
    if (!cur.b && !cur.d && start) begin
      m_k1 = 0; m_k2 = 0; m_s1 = 0; m_s2 = 0;
      build_run(int'(high_len), int'(low_len), int'(num_pulses));
    end
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'('0);
    check_outputs();
  endtask

  task automatic set_cfg(input logic st, input int h, input int l, input int n);
    start      = st;
    high_len   = 8'(h);
    low_len    = 8'(l);
    num_pulses = 4'(n);
  endtask

  initial begin
    logic [9:0] pat10;
    logic [5:0] pat6;
    int         busy_cycles;

    Reset = 1'b0;
    set_cfg(1'b0, 0, 0, 0);
    K1 = 1'b0; K2 = 1'b0;
    model_reset();
    #12;
    check_outputs();
    Reset = 1'b1;
    repeat (2) step();

    // Reset mid-run while A is high, with K1 counted once beforehand.
    set_cfg(1'b1, 5, 5, 3);
    step();
    set_cfg(1'b0, 5, 5, 3);
    K1 = 1'b1;
    step();
    chk("pre_reset_k1", k1_cnt, 1);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 Reset = 1'b1;
    K1 = 1'b0;
    step();

    // Basic run H=3 L=2 N=2, with start pulses and config churn while busy.
    set_cfg(1'b1, 3, 2, 2);
    step();
    pat10 = '0;
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      pat10 = {pat10[8:0], A};
      if (busy) busy_cycles++;
      set_cfg(1'((i % 3) == 0), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              int'($urandom_range(0, 15)));
      if (i < 9) step();
    end
    chk("basic_pattern", pat10, 10'b1110011100);
    chk("basic_busy_len", busy_cycles, 10);
    start = 1'b0;
    step();
    chk("basic_done", done, 1);
    step();
    chk("basic_done_once", done, 0);

    // Zero-length phases.
    set_cfg(1'b1, 0, 0, 3);
    step();
    set_cfg(1'b0, 0, 0, 0);
    pat6 = '0;
    for (int i = 0; i < 6; i++) begin
      pat6 = {pat6[4:0], A};
      if (i < 5) step();
    end
    chk("zero_pattern", pat6, 6'b101010);
    repeat (2) step();

    // Empty run.
    set_cfg(1'b1, 4, 4, 0);
    step();
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_A", A, 0);
    start = 1'b0;
    step();
    chk("empty_done_once", done, 0);

    // Saturation on the narrow instance: five K1 rising edges in one run.
    set_cfg(1'b1, 12, 12, 1);
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      K1 = ~K1;
      step();
    end
    chk("sat_k1_at_3", s_k1, 3);
    K1 = 1'b0;
    repeat (20) step();
    set_cfg(1'b1, 2, 2, 2);
    step();
    chk("sat_k1_cleared", s_k1, 0);
    start = 1'b0;
    repeat (12) step();

    // Randomized traffic, including K activity while idle.
    for (int c = 0; c < 4000; c++) begin
      set_cfg(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
      K1 = 1'($urandom_range(0, 1));
      K2 = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
